sonar_dist_filter: RTL
======================

// Module: sonar_dist_filter
// PURPOSE
//  Downstream consumer of the ultrasonic ranging stage. Accepts per-measurement distance words,
//  rejects out-of-range samples, keeps a 2^AVG_LOG2-sample moving average, and drives a
//  hysteretic obstacle flag plus a stale-sensor watchdog. The robotic-arm motion controller
//  uses these outputs to halt the arm. Both obstacle and stale fail safe: the arm halts.
// PARAMETERS
//  DW          16          distance word width (cm)
//  AVG_LOG2    2           log2 of window depth (N = 4)
//  MAX_CM      400         largest accepted sample; 0 and >MAX_CM rejected
//  NEAR_CM     20          obstacle set when avg_cm <= NEAR_CM
//  FAR_CM      25          obstacle clear when avg_cm >= FAR_CM (NEAR_CM < FAR_CM)
//  TIMEOUT_CYC 12_500_000  clk cycles without an accepted sample before stale (250 ms @ 50 MHz)
// PORTS
//  clk         in   1     system clock; the only clock
//  rst         in   1     asynchronous, active-high reset
//  dist_valid  in   1     single-cycle strobe: dist_cm holds a new measurement
//  dist_cm     in   DW    measured distance, cm
//  avg_valid   out  1     single-cycle strobe: avg_cm updated
//  avg_cm      out  DW    moving average, cm
//  obstacle    out  1     1 = object within threshold or no trusted data
//  stale       out  1     1 = watchdog expired, sensor data untrusted
// BEHAVIOUR
//  - Reset (async, immediate): avg_valid=0, avg_cm=0, obstacle=1, stale=0, window/sum/fill=0,
//    timeout counter=0, state FILL.
//  - Accept: dist_valid=1 and 1<=dist_cm<=MAX_CM. Rejected strobes change nothing, including
//    the timeout counter. dist_cm is ignored when dist_valid=0.
//  - Window: N-entry shift register. Running sum is DW+AVG_LOG2 bits (no overflow).
//    On accept: sum <= sum + new - oldest; shift. The oldest entry is 0 while filling.
//  - avg_cm = sum >> AVG_LOG2 (truncate). It is registered, so avg_valid/avg_cm appear one
//    clk after the accepted strobe.
//  - FSM:
//    FILL : fill count increments on each accept. On the Nth accept -> TRACK, first avg_valid.
//           No avg_valid before that. obstacle held 1.
//    TRACK: every accept produces avg_valid. Obstacle is updated on each avg update:
//             avg <= NEAR_CM       -> 1
//             avg >= FAR_CM        -> 0
//             between thresholds   -> hold
//           In the same cycle as the first avg_valid, the flag is set by the thresholds
//           (in the band, it holds 1).
//    STALE: stale=1, obstacle=1. Window, sum and fill count are flushed to 0 on entry.
//           The next accept is stored as sample 1 -> FILL (fill=1); stale drops on that clock edge.
//  - Watchdog (FILL and TRACK):
//    - Counter clears on accept, otherwise increments.
//    - Counter == TIMEOUT_CYC-1 with no accept that cycle -> STALE on the next edge.
//    - An accept in the expiry cycle wins: counter clears and there is no stale.
//    - Counter holds at 0 while in STALE.
//  - Rejected samples in the expiry cycle do not prevent stale.
//  - Back-to-back strobes (every cycle) are fully supported; there is no backpressure.
// TESTING (bench uses TIMEOUT_CYC=100; other defaults)
//  1 reset, 4 accepts of 100 -> exactly one avg_valid, 1 clk after 4th strobe; avg_cm=100,
//    obstacle 1->0.
//  2 after 1, accepts 10 x4 -> avg 77,55,32,10; obstacle=1 from avg 10. Then 22 x4 -> avg
//    13,16,19,22, obstacle stays 1. Then 30 x2 -> 24 (hold 1), 26 (clear 0).
//  3 strobes with dist_cm=0 and 500 between valid samples -> no avg_valid, sum/avg unchanged,
//    timeout not cleared.
//  4 in TRACK, no strobes for 100 cycles -> stale=1, obstacle=1. Then accepts 50 x4 -> stale=0
//    after 1st, avg_valid only after 4th, avg_cm=50, obstacle=0.
//  5 accept exactly in the expiry cycle (counter=99) -> stale stays 0, counter restarts.
//  6 assert rst asynchronously mid-FILL (2 samples in) -> outputs at reset values before the
//    next edge. Then 4 new samples are needed before any avg_valid.

Source files
------------

// File: rtl/sonar_dist_filter.sv
// Range filter for ultrasonic distance words: window average, obstacle flag, stale watchdog.
// Obstacle and stale both fail safe so the arm controller halts on either.
module sonar_dist_filter #(
    parameter int DW          = 16,
    parameter int AVG_LOG2    = 2,
    parameter int MAX_CM      = 400,
    parameter int NEAR_CM     = 20,
    parameter int FAR_CM      = 25,
    parameter int TIMEOUT_CYC = 12_500_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dist_valid,
    input  logic [DW-1:0] dist_cm,
    output logic          avg_valid,
    output logic [DW-1:0] avg_cm,
    output logic          obstacle,
    output logic          stale
);

    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = DW + AVG_LOG2;
    localparam int FW = AVG_LOG2 + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        FILL,
        TRACK,
        STALE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [DW-1:0] win [N];
    logic [SW-1:0] sum;
    logic [SW-1:0] sum_nxt;
    logic [FW-1:0] fill;
    logic [TW-1:0] tmo;
    logic [DW-1:0] avg_nxt;
    logic          acc;
    logic          expire;
    logic          full_nxt;
    logic          obs_nxt;

    assign acc      = dist_valid && (dist_cm != '0)
                      && (int'(dist_cm) <= MAX_CM);
    assign expire   = (int'(tmo) == TIMEOUT_CYC - 1);
    assign full_nxt = (int'(fill) == N - 1);
    assign sum_nxt  = sum + SW'(dist_cm) - SW'(win[N-1]);
    assign avg_nxt  = sum_nxt[SW-1:AVG_LOG2];

    // Between the thresholds the flag keeps its previous value.
    always_comb begin
        obs_nxt = obstacle;
        if (int'(avg_nxt) <= NEAR_CM)
            obs_nxt = 1'b1;
        else if (int'(avg_nxt) >= FAR_CM)
            obs_nxt = 1'b0;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            FILL: begin
                if (acc && full_nxt)
                    state_n = TRACK;
                else if (!acc && expire)
                    state_n = STALE;
            end
            TRACK: begin
                if (!acc && expire)
                    state_n = STALE;
            end
            STALE: begin
                if (acc)
                    state_n = FILL;
            end
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= FILL;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avg_valid <= 1'b0;
            avg_cm    <= '0;
            obstacle  <= 1'b1;
            stale     <= 1'b0;
            sum       <= '0;
            fill      <= '0;
            tmo       <= '0;
            for (int i = 0; i < N; i++)
                win[i] <= '0;
        end else begin
            avg_valid <= 1'b0;
            unique case (state)
                STALE: begin
                    tmo <= '0;
                    // Window was flushed on entry, so the sample lands alone.
                    if (acc) begin
                        win[0] <= dist_cm;
                        sum    <= SW'(dist_cm);
                        fill   <= FW'(1);
                        stale  <= 1'b0;
                    end
                end
                default: begin
                    if (acc) begin
                        tmo    <= '0;
                        sum    <= sum_nxt;
                        win[0] <= dist_cm;
                        for (int i = 1; i < N; i++)
                            win[i] <= win[i-1];
                        if (state == FILL)
                            fill <= fill + FW'(1);
                        if (state == TRACK || full_nxt) begin
                            avg_valid <= 1'b1;
                            avg_cm    <= avg_nxt;
                            obstacle  <= obs_nxt;
                        end
                    end else if (expire) begin
                        tmo      <= '0;
                        sum      <= '0;
                        fill     <= '0;
                        stale    <= 1'b1;
                        obstacle <= 1'b1;
                        for (int i = 0; i < N; i++)
                            win[i] <= '0;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
            endcase
        end
    end

endmodule
